// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered read data, occupancy
// count, programmable almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   wr, din      write request and write data
//   rd           read request
//   clr_err      clears the sticky overflow/underflow flags
//   dout         registered read data, held between reads
//   dout_valid   one-cycle pulse, the cycle after an accepted read
//   empty, full, almost_empty, almost_full   decodes of count
//   count        current occupancy, 0..DEPTH
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
//
// Handshake: there is no backpressure on the producer or consumer. A read is
// accepted when rd is high and the FIFO is not empty. A write is accepted
// when wr is high and the FIFO is not full, or when it is full and a read is
// accepted in the same cycle. A rejected request is dropped and only sets
// its sticky error flag. Read data appears on dout one cycle after the
// accepted read, qualified by dout_valid.
module sync_fifo_param #(
  parameter int DWIDTH   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     clr_err,
  output logic [DWIDTH-1:0]        dout,
  output logic                     dout_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf_set;
  logic              unf_set;

  // Flags decode the registered count only, so they never glitch on inputs.
  assign empty        = (count == '0);
  assign full         = (count == FULL_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  assign rd_acc  = rd & ~empty;
  // When full, a write can only go in because the accepted read frees a slot
  // at the same edge.
  assign wr_acc  = wr & (~full | rd_acc);
  assign ovf_set = wr & full & ~rd_acc;
  assign unf_set = rd & empty;

  // Storage is not reset; stale contents are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      dout_valid <= rd_acc;
      if (wr_acc) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_acc) begin
        // Non-blocking read of mem returns the pre-edge contents, so a
        // same-address write in this cycle is not forwarded.
        dout <= mem[rptr];
        rptr <= rptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new error wins over a clear arriving in the same cycle.
      overflow  <= ovf_set | (overflow  & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter DWIDTH, default 8: data width in bits; DWIDTH SHALL be at least 1.
REQ-003 Parameter DEPTH, default 16: number of entries; DEPTH SHALL be a power of 2 and at least 2.
REQ-004 Parameter AF_LEVEL, default DEPTH-2: almost_full is asserted when count >= AF_LEVEL.
REQ-005 Parameter AE_LEVEL, default 2: almost_empty is asserted when count <= AE_LEVEL.
REQ-006 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- wr  in  1  write request
- rd  in  1  read request
- din  in  DWIDTH  write data
- clr_err  in  1  clears the sticky error flags
- dout  out  DWIDTH  registered read data
- dout_valid  out  1  high for one cycle when dout is updated
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AE_LEVEL
- almost_full  out  1  count >= AF_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky flag: a write was rejected
- underflow  out  1  sticky flag: a read was rejected

Function
REQ-007 Read accept SHALL be rd_acc = rd & !empty.
REQ-008 Write accept SHALL be wr_acc = wr & (!full | rd_acc); a write while full is accepted only together with an accepted read.
REQ-009 On wr_acc, din SHALL be stored at mem[wptr], and wptr SHALL increment modulo DEPTH.
REQ-010 On rd_acc, dout SHALL be loaded from mem[rptr] at that clock edge, rptr SHALL increment modulo DEPTH, and dout_valid SHALL be 1 in the following cycle.
REQ-011 Read latency SHALL be one cycle from rd_acc to dout/dout_valid; without rd_acc, dout SHALL hold its value and dout_valid SHALL be 0.
REQ-012 On a simultaneous write and read, a same-address read SHALL return the old memory content; with count >= 1 the entry read is never the entry being written.
REQ-013 count SHALL update as follows:
- +1 on wr_acc only
- -1 on rd_acc only
- unchanged when both or neither are accepted
REQ-014 count SHALL never exceed DEPTH nor go below 0.
REQ-015 All status flags (empty, full, almost_empty, almost_full) SHALL be combinational decodes of registered count.
REQ-016 wr while full without rd_acc SHALL set overflow; the write is dropped and no state other than overflow changes.
REQ-017 rd while empty SHALL set underflow; the read is dropped and dout is held.
REQ-018 When empty, a simultaneous wr and rd SHALL accept the write only, set underflow, and give count = 1.
REQ-019 overflow and underflow SHALL remain set until clr_err or rst; if clr_err and a new error occur in the same cycle, the flag SHALL be set.
REQ-020 The data sequence at dout SHALL be exactly the accepted write sequence, in order, across pointer wrap-around.

Reset
REQ-021 With rst high at a clock edge, the block SHALL set:
- wptr = 0, rptr = 0, count = 0
- dout = 0, dout_valid = 0
- overflow = 0, underflow = 0
- so that empty = 1, almost_empty = 1, full = 0, almost_full = 0
REQ-022 rst SHALL take priority over wr, rd and clr_err in the same cycle; memory contents are not cleared.
REQ-023 A reset in the middle of a burst SHALL discard all stored entries; the first write after reset SHALL land at mem[0].

Verification (DWIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-024 Reset scenario: with rst held for 2 cycles -> count=0, empty=1, full=0, dout=0x00, dout_valid=0, overflow=0, underflow=0.
REQ-025 Fill/drain scenario:
- write 0x00..0x0F -> full=1 after the 16th write; almost_full rises when count=14
- a 17th write sets overflow=1 with count=16
- 16 reads -> dout = 0x00..0x0F in order, one cycle after each read; empty=1 at the end
REQ-026 Full with simultaneous wr+rd: with the FIFO full, wr=rd=1 with din=0xAA -> read accepted, write accepted, count stays 16, overflow stays 0.
REQ-027 Empty with simultaneous wr+rd: with the FIFO empty, wr=rd=1 with din=0x55 -> count=1, underflow=1, dout unchanged; the next read returns 0x55.
REQ-028 Wrap-around: 40 random interleaved writes/reads at occupancy 5-12 -> the output order matches a reference queue, and count matches it every cycle.
REQ-029 Error-flag clear and mid-burst reset:
- with overflow=1, pulse clr_err -> overflow=0
- write 6 entries, assert rst at the 4th -> count=0; the next write of 0x3C then a read returns 0x3C
